// File: rtl/proc_control_fsm.sv
// proc_control_fsm: instruction sequencer for the 8-register bus processor.
// Fetches a 9-bit instruction from DIN and steps it through T0..T3.
module proc_control_fsm #(
    parameter int DATA_W = 16,
    parameter int IR_LSB = 0
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic [8:0]        IR,
    output logic              IRin,
    output logic [7:0]        Rout,
    output logic              Gout,
    output logic              DINout,
    output logic [7:0]        Rin,
    output logic              Ain,
    output logic              Gin,
    output logic              AddSub,
    output logic              Done,
    output logic              Illegal
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [2:0] op;
    logic [2:0] x;
    logic [2:0] y;
    logic [7:0] hot_x;
    logic [7:0] hot_y;

    logic is_mv;
    logic is_mvi;
    logic is_alu;
    logic is_ill;

    logic       irin_c;
    logic [7:0] rout_c;
    logic       gout_c;
    logic       dinout_c;
    logic [7:0] rin_c;
    logic       ain_c;
    logic       gin_c;
    logic       addsub_c;
    logic       done_c;
    logic       ill_c;

    logic unused_din;

    assign unused_din = ^DIN;

    assign op    = IR[8:6];
    assign x     = IR[5:3];
    assign y     = IR[2:0];
    assign hot_x = 8'b1000_0000 >> x;
    assign hot_y = 8'b1000_0000 >> y;

    assign is_ill = op[2];
    assign is_mv  = (op == 3'b000);
    assign is_mvi = (op == 3'b001);
    assign is_alu = (op[2:1] == 2'b01);

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= T0;
        end else begin
            state <= state_nxt;
        end
    end

    // Instruction register loads only on a fetch strobe.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            IR <= '0;
        end else if (irin_c) begin
            IR <= DIN[IR_LSB+8:IR_LSB];
        end
    end

    // Next state and control strobes from state, IR and Run.
    always_comb begin
        state_nxt = state;
        irin_c    = 1'b0;
        rout_c    = '0;
        gout_c    = 1'b0;
        dinout_c  = 1'b0;
        rin_c     = '0;
        ain_c     = 1'b0;
        gin_c     = 1'b0;
        addsub_c  = 1'b0;
        done_c    = 1'b0;
        ill_c     = 1'b0;
        unique case (state)
            T0: begin
                if (Run) begin
                    irin_c    = 1'b1;
                    state_nxt = T1;
                end
            end
            T1: begin
                state_nxt = T0;
                unique case (1'b1)
                    is_ill: begin
                        done_c = 1'b1;
                        ill_c  = 1'b1;
                    end
                    is_mv: begin
                        rout_c = hot_y;
                        rin_c  = hot_x;
                        done_c = 1'b1;
                    end
                    is_mvi: begin
                        dinout_c = 1'b1;
                        rin_c    = hot_x;
                        done_c   = 1'b1;
                    end
                    is_alu: begin
                        rout_c    = hot_x;
                        ain_c     = 1'b1;
                        state_nxt = T2;
                    end
                endcase
            end
            T2: begin
                rout_c    = hot_y;
                gin_c     = 1'b1;
                addsub_c  = IR[6];
                state_nxt = T3;
            end
            T3: begin
                gout_c    = 1'b1;
                rin_c     = hot_x;
                done_c    = 1'b1;
                state_nxt = T0;
            end
        endcase
    end

    assign IRin    = irin_c & Resetn;
    assign Rout    = rout_c & {8{Resetn}};
    assign Gout    = gout_c & Resetn;
    assign DINout  = dinout_c & Resetn;
    assign Rin     = rin_c & {8{Resetn}};
    assign Ain     = ain_c & Resetn;
    assign Gin     = gin_c & Resetn;
    assign AddSub  = addsub_c & Resetn;
    assign Done    = done_c & Resetn;
    assign Illegal = ill_c & Resetn;

endmodule

// File: tb/tb_proc_control_fsm.sv
// tb_proc_control_fsm: directed bench for the processor control FSM.
// Expected strobe patterns are hand-derived per instruction step.
module tb_proc_control_fsm;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        Run;
    logic [15:0] DIN;
    logic [8:0]  IR;
    logic        IRin;
    logic [7:0]  Rout;
    logic        Gout;
    logic        DINout;
    logic [7:0]  Rin;
    logic        Ain;
    logic        Gin;
    logic        AddSub;
    logic        Done;
    logic        Illegal;

    int n_vec = 0;
    int n_err = 0;

    proc_control_fsm #(.DATA_W(16), .IR_LSB(0)) dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .Run     (Run),
        .DIN     (DIN),
        .IR      (IR),
        .IRin    (IRin),
        .Rout    (Rout),
        .Gout    (Gout),
        .DINout  (DINout),
        .Rin     (Rin),
        .Ain     (Ain),
        .Gin     (Gin),
        .AddSub  (AddSub),
        .Done    (Done),
        .Illegal (Illegal)
    );

    always #5 Clock = ~Clock;

    // Packed view: {IRin,Rout,Gout,DINout,Rin,Ain,Gin,AddSub,Done,Illegal}
    logic [23:0] outs;
    assign outs = {IRin, Rout, Gout, DINout, Rin,
                   Ain, Gin, AddSub, Done, Illegal};

    function automatic logic [23:0] pk(
        input logic       irin,
        input logic [7:0] rout,
        input logic       gout,
        input logic       dinout,
        input logic [7:0] rin,
        input logic       ain,
        input logic       gin,
        input logic       addsub,
        input logic       done,
        input logic       ill
    );
        return {irin, rout, gout, dinout, rin,
                ain, gin, addsub, done, ill};
    endfunction

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Bus-select exclusivity and one-hot-or-zero selects, every cycle.
    always @(negedge Clock) begin
        chk("inv_bus", 32'($countones({DINout, Gout, Rout}) <= 1), 32'd1);
        chk("inv_rout", 32'($onehot0(Rout)), 32'd1);
        chk("inv_rin", 32'($onehot0(Rin)), 32'd1);
    end

    initial begin
        Resetn = 1'b0;
        Run    = 1'b1;
        DIN    = 16'h0058;

        // Reset held with Run=1: everything quiet, IR cleared.
        tick();
        #1;
        chk("rst_outs", 32'(outs), 32'(pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        chk("rst_ir", 32'(IR), 32'h0);
        tick();
        chk("rst_outs2", 32'(outs), 32'h0);

        // Release: first cycle fetches mvi R3.
        Resetn = 1'b1;
        #1;
        chk("rel_irin", 32'(outs), 32'(pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));

        // mvi R3,#DIN in T1 with new DIN.
        tick();
        Run = 1'b0;
        DIN = 16'h1234;
        #1;
        chk("mvi_ir", 32'(IR), 32'h058);
        chk("mvi_t1", 32'(outs),
            32'(pk(0, 8'h00, 0, 1, 8'h10, 0, 0, 0, 1, 0)));
        tick();
        #1;
        chk("mvi_after", 32'(outs), 32'h0);

        // sub R2,R5.
        Run = 1'b1;
        DIN = 16'h00D5;
        #1;
        chk("sub_t0", 32'(outs), 32'(pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tick();
        Run = 1'b0;
        #1;
        chk("sub_t1", 32'(outs),
            32'(pk(0, 8'h20, 0, 0, 8'h00, 1, 0, 0, 0, 0)));
        tick();
        #1;
        chk("sub_t2", 32'(outs),
            32'(pk(0, 8'h04, 0, 0, 8'h00, 0, 1, 1, 0, 0)));
        tick();
        #1;
        chk("sub_t3", 32'(outs),
            32'(pk(0, 8'h00, 1, 0, 8'h20, 0, 0, 0, 1, 0)));
        tick();
        #1;
        chk("sub_after", 32'(outs), 32'h0);

        // Back-to-back: mv R0,R7 then add R1,R1 with Run held.
        Run = 1'b1;
        DIN = 16'h0007;
        #1;
        chk("b2b_c1", 32'(outs), 32'(pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tick();
        DIN = 16'h0089;
        #1;
        chk("b2b_c2", 32'(outs),
            32'(pk(0, 8'h01, 0, 0, 8'h80, 0, 0, 0, 1, 0)));
        tick();
        #1;
        chk("b2b_c3", 32'(outs), 32'(pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tick();
        #1;
        chk("b2b_ir", 32'(IR), 32'h089);
        chk("b2b_c4", 32'(outs),
            32'(pk(0, 8'h40, 0, 0, 8'h00, 1, 0, 0, 0, 0)));
        tick();
        #1;
        chk("b2b_c5", 32'(outs),
            32'(pk(0, 8'h40, 0, 0, 8'h00, 0, 1, 0, 0, 0)));
        tick();
        Run = 1'b0;
        #1;
        chk("b2b_c6", 32'(outs),
            32'(pk(0, 8'h00, 1, 0, 8'h40, 0, 0, 0, 1, 0)));
        tick();
        #1;
        chk("b2b_after", 32'(outs), 32'h0);

        // Illegal opcode.
        Run = 1'b1;
        DIN = 16'h01FF;
        #1;
        chk("ill_t0", 32'(outs), 32'(pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tick();
        Run = 1'b0;
        #1;
        chk("ill_ir", 32'(IR), 32'h1FF);
        chk("ill_t1", 32'(outs),
            32'(pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1)));
        tick();
        #1;
        chk("ill_after", 32'(outs), 32'h0);

        // Reset in T2 of add R1,R2.
        Run = 1'b1;
        DIN = 16'h008A;
        tick();
        Run = 1'b0;
        #1;
        chk("ab_t1", 32'(outs),
            32'(pk(0, 8'h40, 0, 0, 8'h00, 1, 0, 0, 0, 0)));
        tick();
        #1;
        chk("ab_t2", 32'(outs),
            32'(pk(0, 8'h20, 0, 0, 8'h00, 0, 1, 0, 0, 0)));
        Resetn = 1'b0;
        #1;
        chk("ab_rst_outs", 32'(outs), 32'h0);
        chk("ab_rst_ir", 32'(IR), 32'h0);
        tick();
        chk("ab_hold", 32'(outs), 32'h0);
        Resetn = 1'b1;
        #1;
        chk("ab_rel_t0", 32'(outs), 32'h0);

        // Next fetch after abort: mv R5,R2.
        tick();
        chk("ab_idle", 32'(outs), 32'h0);
        Run = 1'b1;
        DIN = 16'h002A;
        #1;
        chk("re_t0", 32'(outs), 32'(pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tick();
        Run = 1'b0;
        #1;
        chk("re_t1", 32'(outs),
            32'(pk(0, 8'h20, 0, 0, 8'h04, 0, 0, 0, 1, 0)));
        tick();
        #1;
        chk("re_after", 32'(outs), 32'h0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
